// File: rtl/step_tick_gen.sv
// step_tick_gen: single-cycle enable strobe for the waveform generator's
// phase/select counters. Free-run mode emits a tick every P clk cycles,
// P = max(div_act, 1). Single-step mode emits one tick per button press.
// Optional build macro STEP_TICK_DEBOUNCE_EN: when defined, the button path
// includes a DEB_CYCLES debouncer. When undefined, a press is the rising
// edge of the synchronized button (clean bench-driven input).
module step_tick_gen #(
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 25000000,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             run,
    input  logic             step_btn,
    output logic             tick,
    output logic             running
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DEFAULT_DIV);

    // Elaboration-time sanity check on the debounce length.
    if (DEB_CYCLES < 1) begin : g_param_check
        $error("step_tick_gen: DEB_CYCLES must be at least 1");
    end

    // Reload value for the down-counter: P-1, with a zero period treated as 1.
    function automatic logic [DIV_W-1:0] period_m1(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d == DIV_ZERO) begin
            r = DIV_ZERO;
        end else begin
            r = d - DIV_ONE;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    logic sync1_r;
    logic sync2_r;
    logic step_pulse_r;

    // Two-flop synchronizer for the asynchronous push button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= step_btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef STEP_TICK_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1'b1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_lvl_r;
    logic             deb_prev_r;

    // Debouncer: accept a level change only after DEB_CYCLES stable cycles,
    // then emit a one-cycle pulse on the debounced rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt_r    <= DEB_ZERO;
            deb_lvl_r    <= 1'b0;
            deb_prev_r   <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            if (sync2_r != deb_lvl_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    deb_lvl_r <= ~deb_lvl_r;
                    deb_cnt_r <= DEB_ZERO;
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_ONE;
                end
            end else begin
                deb_cnt_r <= DEB_ZERO;
            end
            deb_prev_r   <= deb_lvl_r;
            step_pulse_r <= deb_lvl_r & ~deb_prev_r;
        end
    end
`else
    logic sync_prev_r;

    // Rising-edge detect directly on the synchronized button (no debounce).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_prev_r  <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            sync_prev_r  <= sync2_r;
            step_pulse_r <= sync2_r & ~sync_prev_r;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Period registers and tick FSM
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_s;
    logic [DIV_W-1:0] div_act_r;
    logic [DIV_W-1:0] div_act_s;
    logic [DIV_W-1:0] div_shadow_r;
    logic [DIV_W-1:0] div_shadow_s;
    logic [DIV_W-1:0] eff_div_s;
    logic             pend_r;
    logic             pend_s;
    logic             pend_clr_s;
    logic             tick_r;
    logic             tick_s;
    logic             running_r;
    logic             running_s;

    // Next-state logic: period apply, count-down, tick generation.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        div_act_s    = div_act_r;
        tick_s       = 1'b0;
        pend_clr_s   = 1'b0;
        // A pending period takes effect at the same edge the counter reloads.
        eff_div_s    = pend_r ? div_shadow_r : div_act_r;

        case (state_r)
            ST_IDLE: begin
                if (pend_r) begin
                    div_act_s  = div_shadow_r;
                    pend_clr_s = 1'b1;
                end else begin
                    div_act_s  = div_act_r;
                end
                if (run) begin
                    // Run has priority; a coincident step is dropped.
                    state_s = ST_RUN;
                    cnt_s   = period_m1(eff_div_s);
                end else if (step_pulse_r) begin
                    tick_s = 1'b1;
                end else begin
                    tick_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    // Partial count is discarded, no tick.
                    state_s = ST_IDLE;
                    cnt_s   = DIV_ZERO;
                end else if (cnt_r == DIV_ZERO) begin
                    tick_s = 1'b1;
                    cnt_s  = period_m1(eff_div_s);
                    if (pend_r) begin
                        div_act_s  = div_shadow_r;
                        pend_clr_s = 1'b1;
                    end else begin
                        div_act_s  = div_act_r;
                    end
                end else begin
                    cnt_s = cnt_r - DIV_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = DIV_ZERO;
            end
        endcase

        // A new load always wins over the clear of an older one.
        if (div_load) begin
            div_shadow_s = div_val;
            pend_s       = 1'b1;
        end else if (pend_clr_s) begin
            div_shadow_s = div_shadow_r;
            pend_s       = 1'b0;
        end else begin
            div_shadow_s = div_shadow_r;
            pend_s       = pend_r;
        end

        running_s = (state_s == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= DIV_ZERO;
            div_act_r    <= DIV_DEF;
            div_shadow_r <= DIV_DEF;
            pend_r       <= 1'b0;
            tick_r       <= 1'b0;
            running_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            div_act_r    <= div_act_s;
            div_shadow_r <= div_shadow_s;
            pend_r       <= pend_s;
            tick_r       <= tick_s;
            running_r    <= running_s;
        end
    end

    assign tick    = tick_r;
    assign running = running_r;

endmodule

// File: tb/tb_step_tick_gen.sv
// Self-checking bench for step_tick_gen. The reference model tracks the
// absolute cycle at which the next free-run tick is due and predicts
// single-step ticks from the button sampling history (4-cycle latency).
module tb_step_tick_gen;

    localparam int DW  = 8;
    localparam int DEF = 7;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] div_val;
    logic          div_load;
    logic          run;
    logic          step_btn;
    logic          tick;
    logic          running;

    int n_cmp;
    int n_err;

    step_tick_gen #(
        .DIV_W      (DW),
        .DEFAULT_DIV(DEF),
        .DEB_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_val (div_val),
        .div_load(div_load),
        .run     (run),
        .step_btn(step_btn),
        .tick    (tick),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int unsigned   cyc;
    logic          m_tick;
    logic          m_run;
    logic [DW-1:0] m_act;
    logic [DW-1:0] m_sh;
    logic          m_pend;
    int unsigned   m_due;
    logic [7:0]    hist;

    initial begin
        cyc    = 0;
        m_tick = 1'b0;
        m_run  = 1'b0;
        m_act  = DW'(DEF);
        m_sh   = DW'(DEF);
        m_pend = 1'b0;
        m_due  = 0;
        hist   = 8'h00;
    end

    // Behavioural model, evaluated with the inputs sampled at each edge.
    always @(posedge clk) begin : ref_model
        logic [DW-1:0] eff;
        int unsigned   p;
        logic          stp;
        logic          t;
        logic          clr;
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_tick <= 1'b0;
            m_run  <= 1'b0;
            m_act  <= DW'(DEF);
            m_sh   <= DW'(DEF);
            m_pend <= 1'b0;
            m_due  <= 0;
            hist[cyc % 8]       <= 1'b0;
            hist[(cyc + 7) % 8] <= 1'b0;
            hist[(cyc + 6) % 8] <= 1'b0;
        end else begin
`ifdef STEP_TICK_DEBOUNCE_EN
            stp = 1'b0;
`else
            // Press seen at edge k-3 (low at k-4) produces a tick at edge k.
            stp = hist[(cyc + 5) % 8] & ~hist[(cyc + 4) % 8];
`endif
            eff = m_pend ? m_sh : m_act;
            p   = (eff == 0) ? 1 : int'(eff);
            t   = 1'b0;
            clr = 1'b0;
            if (!m_run) begin
                if (m_pend) begin
                    m_act <= m_sh;
                    clr = 1'b1;
                end
                if (run) begin
                    m_run <= 1'b1;
                    m_due <= cyc + p;
                end else begin
                    t = stp;
                end
            end else if (!run) begin
                m_run <= 1'b0;
            end else if (cyc == m_due) begin
                t = 1'b1;
                m_due <= cyc + p;
                if (m_pend) begin
                    m_act <= m_sh;
                    clr = 1'b1;
                end
            end
            m_tick <= t;
            if (div_load) begin
                m_sh   <= div_val;
                m_pend <= 1'b1;
            end else if (clr) begin
                m_pend <= 1'b0;
            end
            hist[cyc % 8] <= step_btn;
        end
    end

    task automatic test_reset();
        rst_n    = 1'b0;
        run      = 1'b1;
        step_btn = 1'b1;
        div_load = 1'b1;
        div_val  = 8'd3;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset_tick e=%0d got=%b exp=0", e, tick);
            end
            n_cmp++;
            if (running !== 1'b0) begin
                n_err++;
                $display("FAIL reset_running e=%0d got=%b exp=0", e, running);
            end
        end
        run      = 1'b0;
        step_btn = 1'b0;
        div_load = 1'b0;
    endtask

    // Edge 0 is a reset; run at 10 with P=4; reload to 2 at edge 15.
    task automatic test_period_reload();
        logic et;
        logic er;
        for (int e = 0; e <= 26; e++) begin
            rst_n    = (e != 0);
            div_load = (e == 2) || (e == 15);
            div_val  = (e == 15) ? 8'd2 : 8'd4;
            run      = (e >= 10);
            @(negedge clk);
            et = (e == 14) || (e == 18) || (e == 20) || (e == 22) || (e == 24) || (e == 26);
            er = (e >= 10);
            n_cmp++;
            if (tick !== et || tick !== m_tick) begin
                n_err++;
                $display("FAIL period_tick e=%0d got=%b exp=%b model=%b", e, tick, et, m_tick);
            end
            n_cmp++;
            if (running !== er || running !== m_run) begin
                n_err++;
                $display("FAIL period_running e=%0d got=%b exp=%b", e, running, er);
            end
        end
        div_load = 1'b0;
        run      = 1'b0;
    endtask

    // div_val=0 behaves as P=1: tick every cycle while running.
    task automatic test_div_zero();
        logic et;
        logic er;
        for (int e = 0; e <= 15; e++) begin
            rst_n    = (e != 0);
            div_load = (e == 1);
            div_val  = 8'd0;
            run      = (e >= 3) && (e < 12);
            @(negedge clk);
            et = (e >= 4) && (e <= 11);
            er = (e >= 3) && (e <= 11);
            n_cmp++;
            if (tick !== et || tick !== m_tick) begin
                n_err++;
                $display("FAIL divzero_tick e=%0d got=%b exp=%b", e, tick, et);
            end
            n_cmp++;
            if (running !== er || running !== m_run) begin
                n_err++;
                $display("FAIL divzero_running e=%0d got=%b exp=%b", e, running, er);
            end
        end
        div_load = 1'b0;
    endtask

    // P=6: run dropped before terminal count gives no tick; restart at 20.
    task automatic test_abort();
        logic et;
        logic er;
        for (int e = 0; e <= 33; e++) begin
            rst_n    = (e != 0);
            div_load = (e == 1);
            div_val  = 8'd6;
            run      = ((e >= 10) && (e < 13)) || (e >= 20);
            @(negedge clk);
            et = (e == 26) || (e == 32);
            er = ((e >= 10) && (e <= 12)) || (e >= 20);
            n_cmp++;
            if (tick !== et || tick !== m_tick) begin
                n_err++;
                $display("FAIL abort_tick e=%0d got=%b exp=%b", e, tick, et);
            end
            n_cmp++;
            if (running !== er || running !== m_run) begin
                n_err++;
                $display("FAIL abort_running e=%0d got=%b exp=%b", e, running, er);
            end
        end
        div_load = 1'b0;
        run      = 1'b0;
    endtask

    // Reset at edge 12 kills the tick due at 14 and restores DEFAULT_DIV (7).
    task automatic test_reset_midrun();
        logic et;
        logic er;
        for (int e = 0; e <= 22; e++) begin
            rst_n    = (e != 0) && (e != 12);
            div_load = (e == 1);
            div_val  = 8'd4;
            run      = (e >= 10);
            @(negedge clk);
            et = (e == 20);
            er = (e == 10) || (e == 11) || (e >= 13);
            n_cmp++;
            if (tick !== et || tick !== m_tick) begin
                n_err++;
                $display("FAIL midrst_tick e=%0d got=%b exp=%b", e, tick, et);
            end
            n_cmp++;
            if (running !== er || running !== m_run) begin
                n_err++;
                $display("FAIL midrst_running e=%0d got=%b exp=%b", e, running, er);
            end
        end
        run   = 1'b0;
        rst_n = 1'b1;
    endtask

`ifdef STEP_TICK_DEBOUNCE_EN
    // Bouncy press gives exactly one tick; bouncy release gives none.
    task automatic test_button();
        int n_press;
        int n_rel;
        n_press = 0;
        n_rel   = 0;
        run     = 1'b0;
        for (int e = 0; e <= 80; e++) begin
            rst_n = (e != 0);
            if ((e >= 1 && e <= 20) || (e >= 41 && e <= 60)) begin
                step_btn = (((e - 1) / 3) % 2) == 0;
            end else begin
                step_btn = (e >= 21 && e <= 40);
            end
            @(negedge clk);
            if (tick === 1'b1) begin
                if (e <= 43) n_press++;
                else n_rel++;
            end
        end
        n_cmp++;
        if (n_press !== 1) begin
            n_err++;
            $display("FAIL deb_press_ticks got=%0d exp=1", n_press);
        end
        n_cmp++;
        if (n_rel !== 0) begin
            n_err++;
            $display("FAIL deb_release_ticks got=%0d exp=0", n_rel);
        end
        step_btn = 1'b0;
    endtask
`else
    // Clean press: tick 4 cycles later; press colliding with run is dropped;
    // then random presses against the model.
    task automatic test_button();
        logic et;
        for (int e = 0; e <= 28; e++) begin
            rst_n    = (e != 0);
            step_btn = ((e >= 2) && (e <= 8)) || ((e >= 20) && (e <= 24));
            run      = (e >= 23);
            @(negedge clk);
            et = (e == 5);
            n_cmp++;
            if (tick !== et || tick !== m_tick) begin
                n_err++;
                $display("FAIL step_tick e=%0d got=%b exp=%b", e, tick, et);
            end
            n_cmp++;
            if (running !== (e >= 23)) begin
                n_err++;
                $display("FAIL step_running e=%0d got=%b exp=%b", e, running, (e >= 23));
            end
        end
        run = 1'b0;
        for (int e = 0; e < 300; e++) begin
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            @(negedge clk);
            n_cmp++;
            if (tick !== m_tick) begin
                n_err++;
                $display("FAIL step_rand_tick e=%0d got=%b exp=%b", e, tick, m_tick);
            end
        end
        step_btn = 1'b0;
    endtask
`endif

    // Random mix of run toggles, period loads, button activity and resets.
    task automatic test_random();
        rst_n = 1'b1;
        for (int e = 0; e < 3000; e++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            div_load = ($urandom_range(0, 19) == 0);
            div_val  = DW'($urandom_range(0, 9));
            rst_n    = ($urandom_range(0, 299) != 0);
`ifndef STEP_TICK_DEBOUNCE_EN
            if ($urandom_range(0, 4) == 0) step_btn = ~step_btn;
`endif
            @(negedge clk);
            n_cmp++;
            if (tick !== m_tick) begin
                n_err++;
                $display("FAIL rand_tick e=%0d got=%b exp=%b", e, tick, m_tick);
            end
            n_cmp++;
            if (running !== m_run) begin
                n_err++;
                $display("FAIL rand_running e=%0d got=%b exp=%b", e, running, m_run);
            end
        end
        div_load = 1'b0;
        run      = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        div_val  = 8'd0;
        div_load = 1'b0;
        run      = 1'b0;
        step_btn = 1'b0;
        test_reset();
        test_period_reload();
        test_div_zero();
        test_abort();
        test_reset_midrun();
        test_button();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/step_tick_gen.md
Name: step_tick_gen

Overview:
- Enable-pulse source for the waveform generator's phase/select counters.
- Produces a single-cycle `tick` strobe that drives the `enable` input of the downstream wrap-around selector counter.
- In free-run mode, `tick` fires at a programmable period.
- In single-step mode, one `tick` is produced per debounced press of a front-panel button, for manual stepping during lab bring-up.

Parameters:
- DIV_W, 26, width of period register and down-counter.
- DEFAULT_DIV, 25000000, period in clk cycles loaded at reset (1 Hz at 25 MHz).
- DEB_CYCLES, 250000, consecutive stable cycles required to accept a button level change (10 ms at 25 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- div_val  in  DIV_W  new period in cycles.
- div_load  in  1  one-cycle strobe; capture div_val.
- run  in  1  level; 1 = free-run, 0 = single-step.
- step_btn  in  1  raw asynchronous push button, active-high.
- tick  out  1  one-cycle enable strobe to downstream counter.
- running  out  1  1 while FSM is in RUN.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - tick=0, running=0, FSM=IDLE.
  - div_act=DEFAULT_DIV, div_shadow=DEFAULT_DIV, pend=0, cnt=0.
  - Synchronizer FFs=0, debounced level=0, debounce counter=0.
  - Reset mid-count or mid-debounce aborts everything; no tick is emitted in the reset cycle or the cycle after.
- Period rule: effective period P = max(div_act, 1). div_val=0 is treated as 1.
- div_load:
  - On an edge with div_load=1: div_shadow<=div_val and pend<=1.
  - In IDLE, div_act<=div_shadow on the following edge.
  - In RUN, div_act<=div_shadow only on the edge where a tick is generated (terminal count). The current period is never truncated or stretched.
  - A second div_load before the apply overwrites div_shadow (last wins).
- Button path:
  - 2-FF synchronizer.
  - Debouncer: the counter increments while the synchronized level differs from the debounced level and clears otherwise. When it reaches DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - step_pulse (registered) = debounced rising edge, exactly 1 cycle wide.
  - Release edges produce nothing.
- FSM, IDLE:
  - running=0.
  - step_pulse=1 -> tick=1 on the next cycle (one tick per press).
  - run=1 sampled at edge N -> go to RUN, cnt<=P-1.
  - If run=1 and step_pulse=1 occur together, run wins and the step is discarded.
- FSM, RUN:
  - running=1. cnt decrements each cycle.
  - When cnt==0: tick=1 next cycle, cnt<=P-1 (using the newly applied div_act if pend), pend<=0.
  - First tick is at cycle N+P; thereafter one tick every P cycles.
  - P=1 gives tick high every cycle.
  - step_pulse is ignored.
  - run=0 sampled -> IDLE on that edge. The partial count is discarded and no tick is generated. A tick already registered for that cycle still completes (1 cycle).
- tick is registered and never wider than 1 cycle except with P=1 in RUN.
- Counter width: cnt is DIV_W bits. No overflow is possible because cnt ≤ 2^DIV_W−2.

Optional Feature:
- Macro: STEP_TICK_DEBOUNCE_EN.
- Defined: button path as above (synchronizer + DEB_CYCLES debouncer + edge detect).
- Undefined: debouncer removed. step_pulse = rising edge of the synchronized step_btn (2-FF sync + edge FF), for simulation or benches that drive a clean button. Press-to-tick latency becomes 4 cycles. DEB_CYCLES is unused.

Test Plan:
- Reset then run=1 at edge 10 with DEFAULT overridden by div_load div_val=4 at edge 2 -> running=1 from edge 10; tick high at cycles 14, 18, 22, each 1 cycle wide.
- RUN with P=4, div_load div_val=2 at cycle 15 -> ticks at 18 (old period completes), then 20, 22, 24.
- div_val=0 loaded, run=1 -> tick high every cycle while running=1. Drop run -> tick low within 1 cycle, running=0.
- IDLE, DEB_CYCLES=8, step_btn bounces 1/0 every 3 cycles for 20 cycles then holds 1 for 20 -> exactly one tick. Release with bounce -> zero ticks.
- run=1 at cycle 10 with P=6, run=0 at cycle 13 -> no tick; running falls at 13. run=1 again at 20 -> first tick at 26.
- rst_n=0 for one edge at cycle 12 during RUN P=4 (tick due at 14) -> no tick at 14; div_act returns to DEFAULT_DIV, running=0.
